svc_rv_dmem_bridge: RTL and testbench

SVC_RV_DMEM_BRIDGE -- requirements
Module: svc_rv_dmem_bridge

---
 rtl/svc_rv_dmem_bridge_if.sv | 36 +++
 rtl/svc_rv_dmem_bridge.sv | 161 ++++++++++++++++
 tb/tb_svc_rv_dmem_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_dmem_bridge_if.sv
// Bundles the core-side data-memory port and the backing-memory request/response port.
// The bridge connects through the slave modport; the environment uses the master modport.
interface svc_rv_dmem_bridge_if #(
   parameter int XLEN = 32
);
   logic            dmem_ren;
   logic [XLEN-1:0] dmem_raddr;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_waddr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_wstrb;
   logic            dmem_stall;
   logic            m_valid;
   logic            m_ready;
   logic            m_write;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   logic [3:0]      m_wstrb;
   logic            r_valid;
   logic [XLEN-1:0] r_data;

   modport slave (
      input  dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
      input  m_ready, r_valid, r_data,
      output dmem_rdata, dmem_stall,
      output m_valid, m_write, m_addr, m_wdata, m_wstrb
   );

   modport master (
      output dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
      output m_ready, r_valid, r_data,
      input  dmem_rdata, dmem_stall,
      input  m_valid, m_write, m_addr, m_wdata, m_wstrb
   );
endinterface

// File: rtl/svc_rv_dmem_bridge.sv
// Bridges a stalling RISC-V core data port onto a valid/ready memory request bus with a read response.
// Define SVC_RV_DMEM_BRIDGE_WBUF_EN to compile in a one-entry posted write buffer.
module svc_rv_dmem_bridge #(
   parameter int XLEN = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   svc_rv_dmem_bridge_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WREQ, RREQ, RWAIT} state_t;

   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

   state_t          state, state_nxt;
   logic            m_valid_q, m_valid_nxt;
   logic            m_write_q, m_write_nxt;
   logic [XLEN-1:0] m_addr_q, m_addr_nxt;
   logic [XLEN-1:0] m_wdata_q, m_wdata_nxt;
   logic [3:0]      m_wstrb_q, m_wstrb_nxt;
   logic            rd_pend_q, rd_pend_nxt;
   logic [XLEN-1:0] rd_addr_q, rd_addr_nxt;
   logic [XLEN-1:0] rdata_q, rdata_nxt;
   logic [XLEN-1:0] waddr_word, raddr_word;
   logic            handshake;
   logic            stall;

   assign waddr_word = bus.dmem_waddr & WORD_MASK;
   assign raddr_word = bus.dmem_raddr & WORD_MASK;
   assign handshake  = m_valid_q && bus.m_ready;

`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
   logic wb_valid_q, wb_valid_nxt;

   // A full buffer holds back any new access until it drains, keeping reads behind older writes.
   assign stall = (state != IDLE) || (wb_valid_q && (bus.dmem_we || bus.dmem_ren));
`else
   assign stall = (state != IDLE);
`endif

   always_comb begin
      state_nxt   = state;
      m_valid_nxt = m_valid_q;
      m_write_nxt = m_write_q;
      m_addr_nxt  = m_addr_q;
      m_wdata_nxt = m_wdata_q;
      m_wstrb_nxt = m_wstrb_q;
      rd_pend_nxt = rd_pend_q;
      rd_addr_nxt = rd_addr_q;
      rdata_nxt   = rdata_q;
`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
      wb_valid_nxt = wb_valid_q;
`endif
      case (state)
         IDLE: begin
`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
            if (wb_valid_q) begin
               if (handshake) begin
                  wb_valid_nxt = 1'b0;
                  m_valid_nxt  = 1'b0;
                  m_write_nxt  = 1'b0;
               end
            end else if (bus.dmem_we && !bus.dmem_ren) begin
               m_write_nxt  = 1'b1;
               m_addr_nxt   = waddr_word;
               m_wdata_nxt  = bus.dmem_wdata;
               m_wstrb_nxt  = bus.dmem_wstrb;
               m_valid_nxt  = 1'b1;
               wb_valid_nxt = 1'b1;
            end else
`endif
            if (bus.dmem_we) begin
               // The write goes out first; a same-cycle read is parked until it is accepted.
               m_write_nxt = 1'b1;
               m_addr_nxt  = waddr_word;
               m_wdata_nxt = bus.dmem_wdata;
               m_wstrb_nxt = bus.dmem_wstrb;
               rd_pend_nxt = bus.dmem_ren;
               rd_addr_nxt = raddr_word;
               m_valid_nxt = 1'b1;
               state_nxt   = WREQ;
            end else if (bus.dmem_ren) begin
               m_write_nxt = 1'b0;
               m_addr_nxt  = raddr_word;
               m_wdata_nxt = '0;
               m_wstrb_nxt = 4'b0000;
               m_valid_nxt = 1'b1;
               state_nxt   = RREQ;
            end
         end
         WREQ: begin
            if (handshake) begin
               if (rd_pend_q) begin
                  m_write_nxt = 1'b0;
                  m_addr_nxt  = rd_addr_q;
                  m_wdata_nxt = '0;
                  m_wstrb_nxt = 4'b0000;
                  rd_pend_nxt = 1'b0;
                  state_nxt   = RREQ;
               end else begin
                  m_valid_nxt = 1'b0;
                  m_write_nxt = 1'b0;
                  state_nxt   = IDLE;
               end
            end
         end
         RREQ: begin
            if (handshake) begin
               m_valid_nxt = 1'b0;
               state_nxt   = RWAIT;
            end
         end
         RWAIT: begin
            if (bus.r_valid) begin
               rdata_nxt = bus.r_data;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         m_valid_q <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= 4'b0000;
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         rdata_q   <= '0;
`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
         wb_valid_q <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         m_valid_q <= m_valid_nxt;
         m_write_q <= m_write_nxt;
         m_addr_q  <= m_addr_nxt;
         m_wdata_q <= m_wdata_nxt;
         m_wstrb_q <= m_wstrb_nxt;
         rd_pend_q <= rd_pend_nxt;
         rd_addr_q <= rd_addr_nxt;
         rdata_q   <= rdata_nxt;
`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
         wb_valid_q <= wb_valid_nxt;
`endif
      end
   end

   assign bus.dmem_stall = stall;
   assign bus.dmem_rdata = rdata_q;
   assign bus.m_valid    = m_valid_q;
   assign bus.m_write    = m_write_q;
   assign bus.m_addr     = m_addr_q;
   assign bus.m_wdata    = m_wdata_q;
   assign bus.m_wstrb    = m_wstrb_q;

endmodule

// File: tb/tb_svc_rv_dmem_bridge.sv
// Self-checking bench for svc_rv_dmem_bridge: a behavioural backing memory plus a word-array reference
// model of what the core should read back; follows SVC_RV_DMEM_BRIDGE_WBUF_EN when it is defined.
module tb_svc_rv_dmem_bridge;

`ifdef SVC_RV_DMEM_BRIDGE_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } hs_t;

   logic clk;
   logic rst_n;

   svc_rv_dmem_bridge_if #(.XLEN(32)) bus ();

   svc_rv_dmem_bridge #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   hs_t         hs_q[$];
   hs_t         exp_q[$];
   logic [31:0] bk_mem [256];
   logic [31:0] ref_mem [256];
   int          checks = 0;
   int          errors = 0;
   int          rdy_fixed = 0;
   int          rsp_fixed = 0;
   bit          rdy_random = 1'b0;
   bit          rsp_random = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] global time limit reached");
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic timeout_fail(input string tag);
      checks++;
      errors++;
      $error("[TB] FAIL %s: cycle budget expired, observed=stall expected=progress", tag);
   endtask

   task automatic ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      for (int b = 0; b < 4; b++)
         if (strb[b]) ref_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic expect_hs(input logic w, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      hs_t e;
      e.w = w;
      e.a = {addr[31:2], 2'b00};
      e.d = data;
      e.s = strb;
      exp_q.push_back(e);
   endtask

   // Backing memory: accepts after a chosen delay, logs every handshake, answers reads later.
   initial begin : responder
      bit          req_seen;
      bit          rsp_pending;
      int          rdy_cnt;
      int          rsp_cnt;
      logic [31:0] rsp_data;
      hs_t         snap;
      hs_t         cur;
      req_seen = 1'b0;
      rsp_pending = 1'b0;
      rdy_cnt = 0;
      rsp_cnt = 0;
      rsp_data = '0;
      bus.m_ready = 1'b0;
      bus.r_valid = 1'b0;
      bus.r_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.r_valid = 1'b0;
         bus.r_data  = $urandom;
         if (rsp_pending) begin
            if (rsp_cnt == 0) begin
               bus.r_valid = 1'b1;
               bus.r_data  = rsp_data;
               rsp_pending = 1'b0;
            end else begin
               rsp_cnt--;
            end
         end
         bus.m_ready = 1'b0;
         if (!rst_n) begin
            req_seen = 1'b0;
         end else if (bus.m_valid) begin
            cur.w = bus.m_write;
            cur.a = bus.m_addr;
            cur.d = bus.m_wdata;
            cur.s = bus.m_wstrb;
            if (!req_seen) begin
               req_seen = 1'b1;
               snap = cur;
               rdy_cnt = rdy_random ? int'($urandom_range(0, 3)) : rdy_fixed;
            end else begin
               check_output("stable_addr", cur.a, snap.a);
               check_output("stable_ctrl", {cur.w, cur.s, cur.d[26:0]}, {snap.w, snap.s, snap.d[26:0]});
            end
            if (rdy_cnt == 0) begin
               bus.m_ready = 1'b1;
               req_seen = 1'b0;
               hs_q.push_back(cur);
               if (cur.w) begin
                  for (int b = 0; b < 4; b++)
                     if (cur.s[b]) bk_mem[cur.a[9:2]][8*b +: 8] = cur.d[8*b +: 8];
               end else begin
                  rsp_pending = 1'b1;
                  rsp_cnt = rsp_random ? int'($urandom_range(0, 3)) : rsp_fixed;
                  rsp_data = bk_mem[cur.a[9:2]];
               end
            end else begin
               rdy_cnt--;
            end
         end
      end
   end

   // One core access: wait for acceptance, then count stall cycles until the pipeline is released.
   task automatic apply_stimulus(input bit do_w, input bit do_r, input logic [31:0] waddr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] raddr,
                                 output int pre, output int post, output logic [31:0] rdata);
      int n;
      pre = 0;
      post = 0;
      bus.dmem_we    = do_w;
      bus.dmem_ren   = do_r;
      bus.dmem_waddr = waddr;
      bus.dmem_wdata = wdata;
      bus.dmem_wstrb = wstrb;
      bus.dmem_raddr = raddr;
      n = 0;
      forever begin
         #1;
         if (!bus.dmem_stall) break;
         pre++;
         n++;
         if (n > 60) begin
            timeout_fail("accept_wait");
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus.dmem_we    = 1'b0;
      bus.dmem_ren   = 1'b0;
      bus.dmem_waddr = $urandom;
      bus.dmem_wdata = $urandom;
      bus.dmem_wstrb = 4'($urandom);
      bus.dmem_raddr = $urandom;
      n = 0;
      forever begin
         #1;
         if (!bus.dmem_stall) break;
         post++;
         n++;
         if (n > 60) begin
            timeout_fail("release_wait");
            break;
         end
         @(posedge clk);
         #1;
      end
      rdata = bus.dmem_rdata;
   endtask

   task automatic compare_log(input string tag);
      int n;
      n = 0;
      while (hs_q.size() < exp_q.size() && n < 80) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #2;
      check_output({tag, "_hs_count"}, hs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
         check_output({tag, "_hs_write"}, hs_q[i].w, exp_q[i].w);
         check_output({tag, "_hs_addr"}, hs_q[i].a, exp_q[i].a);
         check_output({tag, "_hs_wstrb"}, hs_q[i].s, exp_q[i].s);
         if (exp_q[i].w) check_output({tag, "_hs_wdata"}, hs_q[i].d, exp_q[i].d);
      end
      hs_q.delete();
      exp_q.delete();
   endtask

   initial begin : stimulus
      int          pre, post, pre2, post2;
      logic [31:0] rd;
      logic [31:0] wd;
      rst_n = 1'b1;
      bus.dmem_we = 1'b0;
      bus.dmem_ren = 1'b0;
      bus.dmem_waddr = '0;
      bus.dmem_wdata = '0;
      bus.dmem_wstrb = '0;
      bus.dmem_raddr = '0;
      for (int i = 0; i < 256; i++) begin
         wd = $urandom;
         bk_mem[i] = wd;
         ref_mem[i] = wd;
      end
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check_output("reset_stall", bus.dmem_stall, 1'b0);
      check_output("reset_m_valid", bus.m_valid, 1'b0);
      check_output("reset_m_write", bus.m_write, 1'b0);
      check_output("reset_rdata", bus.dmem_rdata, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single read, immediate ready and response");
      bk_mem[64] = 32'hDEADBEEF;
      ref_mem[64] = 32'hDEADBEEF;
      expect_hs(1'b0, 32'h100, 32'h0, 4'h0);
      apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h100, pre, post, rd);
      check_output("rd100_pre_stall", pre, 0);
      check_output("rd100_stall", post, 2);
      check_output("rd100_rdata", rd, ref_mem[64]);
      compare_log("rd100");

      $display("[TB] unaligned read with ready held low");
      rdy_fixed = 3;
      expect_hs(1'b0, 32'h103, 32'h0, 4'h0);
      apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h103, pre, post, rd);
      check_output("rd103_stall", post, 5);
      check_output("rd103_rdata", rd, ref_mem[64]);
      compare_log("rd103");
      rdy_fixed = 0;

      $display("[TB] simultaneous write and read");
      ref_write(32'h40, 32'h11223344, 4'hF);
      expect_hs(1'b1, 32'h40, 32'h11223344, 4'hF);
      expect_hs(1'b0, 32'h80, 32'h0, 4'h0);
      apply_stimulus(1'b1, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h80, pre, post, rd);
      check_output("wr_rd_stall", post, 3);
      check_output("wr_rd_rdata", rd, ref_mem[32]);
      compare_log("wr_rd");

      $display("[TB] write followed by read in the next cycle");
      wd = $urandom;
      ref_write(32'h40, wd, 4'hF);
      expect_hs(1'b1, 32'h40, wd, 4'hF);
      expect_hs(1'b0, 32'h44, 32'h0, 4'h0);
      apply_stimulus(1'b1, 1'b0, 32'h40, wd, 4'hF, 32'h0, pre, post, rd);
      apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h44, pre2, post2, rd);
      check_output("wbuf_wr_pre", pre, 0);
      check_output("wbuf_wr_post", post, WBUF ? 0 : 1);
      check_output("wbuf_rd_pre", pre2, WBUF ? 1 : 0);
      check_output("wbuf_rd_post", post2, 2);
      check_output("wbuf_rd_rdata", rd, ref_mem[17]);
      compare_log("wbuf");

      $display("[TB] reset while waiting for a read response");
      rsp_fixed = 4;
      expect_hs(1'b0, 32'h108, 32'h0, 4'h0);
      bus.dmem_raddr = 32'h108;
      bus.dmem_ren = 1'b1;
      @(posedge clk);
      #1 bus.dmem_ren = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_output("midrst_stall", bus.dmem_stall, 1'b0);
      check_output("midrst_m_valid", bus.m_valid, 1'b0);
      check_output("midrst_rdata", bus.dmem_rdata, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      check_output("late_rvalid_rdata", bus.dmem_rdata, 32'h0);
      check_output("late_rvalid_stall", bus.dmem_stall, 1'b0);
      check_output("late_rvalid_m_valid", bus.m_valid, 1'b0);
      compare_log("midrst");
      rsp_fixed = 0;
      expect_hs(1'b0, 32'h10C, 32'h0, 4'h0);
      apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10C, pre, post, rd);
      check_output("post_rst_stall", post, 2);
      check_output("post_rst_rdata", rd, ref_mem[67]);
      compare_log("post_rst");

      $display("[TB] back-to-back reads with random delays");
      rdy_random = 1'b1;
      rsp_random = 1'b1;
      expect_hs(1'b0, 32'h0, 32'h0, 4'h0);
      expect_hs(1'b0, 32'h4, 32'h0, 4'h0);
      apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, pre, post, rd);
      check_output("b2b_rdata0", rd, ref_mem[0]);
      apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h4, pre, post, rd);
      check_output("b2b_rdata1", rd, ref_mem[1]);
      compare_log("b2b");

      $display("[TB] random mixed traffic");
      for (int i = 0; i < 40; i++) begin
         int          kind;
         bit          dw, dr;
         logic [31:0] wa, ra, wdat;
         logic [3:0]  ws;
         kind = $urandom_range(0, 3);
         dw = (kind == 1) || (kind == 2);
         dr = (kind != 1);
         wa = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         ra = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         wdat = $urandom;
         ws = 4'($urandom_range(1, 15));
         if (dw) begin
            ref_write(wa, wdat, ws);
            expect_hs(1'b1, wa, wdat, ws);
         end
         if (dr) expect_hs(1'b0, ra, 32'h0, 4'h0);
         apply_stimulus(dw, dr, wa, wdat, ws, ra, pre, post, rd);
         if (dr) check_output("rand_rdata", rd, ref_mem[ra[9:2]]);
      end
      compare_log("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
